// File: rtl/dbg_bridge_pkg.sv
// Shared constants and state encoding for the debug byte bridge.
package dbg_bridge_pkg;

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_RESP  = 3'd5
  } state_e;

  localparam logic [7:0] DBG_CMD_NOP = 8'h00;
  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_TIMEOUT  = 8'hEE;

  localparam int FRAME_LEN = 9;
  localparam int RESP_LEN  = 5;

endpackage

// File: rtl/dbg_byte_bridge.sv
// Host byte stream to debug command port: 9-byte command frame in,
// one debug transaction, 5-byte response (status, read data) out.
module dbg_byte_bridge
  import dbg_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        rx_overrun_o
);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic [7:0]  cmd_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [15:0] tmo_q;
  logic [39:0] resp_q;
  logic        hdr_q;

  // Final data byte is merged on the fly so dbg_data_o is valid in ISSUE.
  logic [31:0] data_full;
  assign data_full = {rx_data_i, data_q[23:0]};

  // NOTE: every state register uses <= so all of them update from the same
  // pre-edge values; blocking here would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q      <= S_CMD;
      cnt_q        <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      tmo_q        <= '0;
      resp_q       <= '0;
      hdr_q        <= 1'b0;
      tx_valid_o   <= 1'b0;
      tx_data_o    <= '0;
      dbg_cmd_o    <= DBG_CMD_NOP;
      dbg_addr_o   <= '0;
      dbg_data_o   <= '0;
      rx_overrun_o <= 1'b0;
    end else begin
      case (state_q)
        S_CMD: begin
          if (rx_valid_i) begin
            cmd_q   <= rx_data_i;
            cnt_q   <= '0;
            state_q <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (rx_valid_i) begin
            addr_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= S_DATA;
          end
        end

        S_DATA: begin
          if (rx_valid_i) begin
            data_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              if (cmd_q == DBG_CMD_NOP) begin
                resp_q     <= {32'h0, ST_OK};
                tx_data_o  <= ST_OK;
                tx_valid_o <= 1'b1;
                hdr_q      <= 1'b1;
                state_q    <= S_RESP;
              end else begin
                dbg_cmd_o  <= cmd_q;
                dbg_addr_o <= addr_q;
                dbg_data_o <= data_full;
                state_q    <= S_ISSUE;
              end
            end
          end
        end

        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          // Completion is checked before the timeout so a coincident ready wins.
          if (dbg_ready_i || tmo_q == 16'(TIMEOUT - 1)) begin
            resp_q     <= dbg_ready_i ? {dbg_data_i, ST_OK} : {32'h0, ST_TIMEOUT};
            tx_data_o  <= dbg_ready_i ? ST_OK : ST_TIMEOUT;
            tx_valid_o <= 1'b1;
            hdr_q      <= 1'b1;
            cnt_q      <= '0;
            dbg_cmd_o  <= DBG_CMD_NOP;
            state_q    <= S_RESP;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end

        S_RESP: begin
          // Status byte is tracked by hdr_q; cnt_q then counts the 4 data bytes.
          if (tx_ready_i) begin
            resp_q    <= resp_q >> 8;
            tx_data_o <= resp_q[15:8];
            hdr_q     <= 1'b0;
            if (!hdr_q) begin
              cnt_q <= cnt_q + 2'd1;
              if (cnt_q == 2'd3) begin
                tx_valid_o <= 1'b0;
                state_q    <= S_CMD;
              end
            end
          end
        end

        default: state_q <= S_CMD;
      endcase

      if (rx_valid_i && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_RESP))
        rx_overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dbg_byte_bridge.sv
// Directed self-checking bench for dbg_byte_bridge (TIMEOUT = 8).
module tb_dbg_byte_bridge;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i = '0;
  logic        dbg_ready_i = 1'b0;
  logic        rx_overrun_o;

  int checks = 0;
  int errors = 0;

  dbg_byte_bridge #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .rx_valid_i   (rx_valid_i),
    .rx_data_i    (rx_data_i),
    .tx_valid_o   (tx_valid_o),
    .tx_data_o    (tx_data_o),
    .tx_ready_i   (tx_ready_i),
    .dbg_cmd_o    (dbg_cmd_o),
    .dbg_addr_o   (dbg_addr_o),
    .dbg_data_o   (dbg_data_o),
    .dbg_data_i   (dbg_data_i),
    .dbg_ready_i  (dbg_ready_i),
    .rx_overrun_o (rx_overrun_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(addr[i*8 +: 8]);
    for (int i = 0; i < 4; i++) send_byte(data[i*8 +: 8]);
  endtask

  // Starting in the cycle after the last frame byte: run until tx_valid_o rises,
  // counting cycles and cycles with an active debug command.
  task automatic run_cmd(input int ready_at, input int rx_at, output int n_active, output int n_cyc);
    n_active = 0;
    n_cyc    = 0;
    while (!tx_valid_o && n_cyc < 40) begin
      if (dbg_cmd_o != 8'h00) n_active++;
      if (n_cyc == ready_at) dbg_ready_i = 1'b1;
      if (n_cyc == rx_at) begin
        rx_valid_i = 1'b1;
        rx_data_i  = 8'h5A;
      end
      tick();
      dbg_ready_i = 1'b0;
      rx_valid_i  = 1'b0;
      n_cyc++;
    end
  endtask

  // Collect five response bytes; r ends up {b4,b3,b2,b1,b0}.
  task automatic recv_resp(input bit rnd, output logic [39:0] r, output int cyc);
    int         nb;
    bit         held;
    logic [7:0] held_data;
    r    = '0;
    nb   = 0;
    cyc  = 0;
    held = 1'b0;
    held_data = '0;
    while (nb < 5 && cyc < 200) begin
      if (held) begin
        check("hold_valid", tx_valid_o, 1);
        check("hold_data", tx_data_o, held_data);
      end
      tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tx_valid_o && tx_ready_i) begin
        r = {tx_data_o, r[39:8]};
        nb++;
      end
      held      = tx_valid_o && !tx_ready_i;
      held_data = tx_data_o;
      tick();
      cyc++;
    end
    tx_ready_i = 1'b0;
  endtask

  int          n_act;
  int          n_cyc;
  int          r_cyc;
  logic [39:0] resp;

  initial begin
    // Reset state
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_cmd", dbg_cmd_o, 0);
    check("rst_addr", dbg_addr_o, 0);
    check("rst_data", dbg_data_o, 0);
    check("rst_overrun", rx_overrun_o, 0);

    // Write frame, ready in the third WAIT cycle
    dbg_data_i = 32'hDEADBEEF;
    send_frame(8'h02, 32'h0000_0100, 32'hDEADBEEF);
    check("wr_issue_cmd", dbg_cmd_o, 8'h02);
    check("wr_issue_addr", dbg_addr_o, 32'h0000_0100);
    check("wr_issue_data", dbg_data_o, 32'hDEADBEEF);
    run_cmd(3, -1, n_act, n_cyc);
    check("wr_cmd_cycles", n_act, 4);
    check("wr_resp_latency", n_cyc, 4);
    check("wr_cmd_cleared", dbg_cmd_o, 8'h00);
    check("wr_status_first", tx_data_o, 8'h00);
    recv_resp(1'b0, resp, r_cyc);
    check("wr_resp", resp, 40'hDEADBEEF_00);
    check("wr_resp_cycles", r_cyc, 5);
    check("wr_tx_idle", tx_valid_o, 0);

    // NOP frame sent back-to-back: no command, zero response, outputs kept
    dbg_data_i = 32'h1357_9BDF;
    send_frame(8'h00, 32'h1234_5678, 32'hCAFE_F00D);
    run_cmd(-1, -1, n_act, n_cyc);
    check("nop_cmd_cycles", n_act, 0);
    check("nop_resp_latency", n_cyc, 0);
    check("nop_addr_kept", dbg_addr_o, 32'h0000_0100);
    check("nop_data_kept", dbg_data_o, 32'hDEADBEEF);
    recv_resp(1'b0, resp, r_cyc);
    check("nop_resp", resp, 40'h0);

    // Timeout: ready never asserted
    dbg_data_i = 32'h1122_3344;
    send_frame(8'h01, 32'hAAAA_5555, 32'h0);
    run_cmd(-1, -1, n_act, n_cyc);
    check("tmo_cmd_cycles", n_act, 9);
    check("tmo_resp_latency", n_cyc, 9);
    check("tmo_cmd_cleared", dbg_cmd_o, 8'h00);
    recv_resp(1'b0, resp, r_cyc);
    check("tmo_resp", resp, 40'h00000000_EE);
    check("tmo_addr_kept", dbg_addr_o, 32'hAAAA_5555);

    // Random back-pressure on the response link
    dbg_data_i = 32'hA1B2_C3D4;
    send_frame(8'h01, 32'h0000_0040, 32'h0000_0000);
    run_cmd(1, -1, n_act, n_cyc);
    check("bp_cmd_cycles", n_act, 2);
    recv_resp(1'b1, resp, r_cyc);
    check("bp_resp", resp, 40'hA1B2C3D4_00);
    check("bp_tx_idle", tx_valid_o, 0);

    // Ready only in ISSUE is ignored; extra byte during WAIT sets overrun
    dbg_data_i = 32'h0BAD_0BAD;
    send_frame(8'h03, 32'h0000_0020, 32'h0000_0030);
    run_cmd(0, 2, n_act, n_cyc);
    check("ovr_tmo_cycles", n_cyc, 9);
    check("ovr_flag", rx_overrun_o, 1);
    recv_resp(1'b0, resp, r_cyc);
    check("ovr_resp", resp, 40'h00000000_EE);
    dbg_data_i = 32'h0000_0066;
    send_frame(8'h02, 32'h0000_0044, 32'h0000_0055);
    check("ovr_next_cmd", dbg_cmd_o, 8'h02);
    check("ovr_next_addr", dbg_addr_o, 32'h0000_0044);
    check("ovr_next_data", dbg_data_o, 32'h0000_0055);
    run_cmd(1, -1, n_act, n_cyc);
    recv_resp(1'b0, resp, r_cyc);
    check("ovr_next_resp", resp, 40'h00000066_00);
    check("ovr_sticky", rx_overrun_o, 1);

    // Reset mid-frame, then a full frame
    send_byte(8'h04);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mrst_overrun", rx_overrun_o, 0);
    check("mrst_addr", dbg_addr_o, 0);
    check("mrst_tx_valid", tx_valid_o, 0);
    dbg_data_i = 32'h7777_8888;
    send_frame(8'h05, 32'h0000_0600, 32'h0000_0700);
    check("mrst_cmd", dbg_cmd_o, 8'h05);
    check("mrst_issue_addr", dbg_addr_o, 32'h0000_0600);
    check("mrst_issue_data", dbg_data_o, 32'h0000_0700);
    run_cmd(1, -1, n_act, n_cyc);
    check("mrst_cmd_cycles", n_act, 2);
    recv_resp(1'b0, resp, r_cyc);
    check("mrst_resp", resp, 40'h77778888_00);
    check("mrst_no_overrun", rx_overrun_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_byte_bridge.md
# dbg_byte_bridge

Byte-stream front-end for the debug module: assembles 9-byte command frames (cmd, addr, data) from a host byte link, drives the debug command port, waits for completion, and returns a 5-byte response (status, read data). Sits between the host transport (UART/JTAG byte PHY) and the `dbg_cmd/addr/data/ready` pins of the core wrapper.

## Interface
- `TIMEOUT`, 1024: cycles to wait for `dbg_ready_i` before aborting; legal range 2..65535.
- `clk`  in  1  system clock.
- `rst_i`  in  1  reset. One clock; reset is synchronous and active-high.
- `rx_valid_i`  in  1  host byte valid; one-cycle strobe, no back-pressure.
- `rx_data_i`  in  8  host byte.
- `tx_valid_o`  out  1  response byte valid.
- `tx_data_o`  out  8  response byte.
- `tx_ready_i`  in  1  host link accepts byte when high with `tx_valid_o`.
- `dbg_cmd_o`  out  8  debug command; 0x00 = NOP.
- `dbg_addr_o`  out  32  debug address.
- `dbg_data_o`  out  32  debug write data.
- `dbg_data_i`  in  32  debug read data.
- `dbg_ready_i`  in  1  debug command complete.
- `rx_overrun_o`  out  1  sticky: host byte arrived while not accepting.

## Operation
- Frame in: byte 0 = cmd, bytes 1-4 = addr LSB first, bytes 5-8 = data LSB first.
- States: `CMD` → `ADDR` (4 bytes) → `DATA` (4 bytes) → `ISSUE` → `WAIT` → `RESP` (5 bytes) → `CMD`.
- 2-bit byte counter shared by `ADDR`, `DATA` and `RESP`; wraps 3→0 on state change.
- `ISSUE`: drive `dbg_cmd_o` = captured cmd; `dbg_addr_o`/`dbg_data_o` = captured values. Lasts 1 cycle.
- `WAIT`: `dbg_cmd_o` held. Completion when `dbg_ready_i`=1: latch `dbg_data_i`, status=0x00, `dbg_cmd_o`→0x00, go to `RESP`.
- Timeout counter starts at 0 in `ISSUE`, increments each `WAIT` cycle. If it reaches `TIMEOUT` with no ready: status=0xEE, read data=0, `dbg_cmd_o`→0x00, go to `RESP`. If ready and timeout coincide, ready wins.
- NOP frame (cmd=0x00): `ISSUE`/`WAIT` skipped; `RESP` sends status 0x00 and data 0x00000000.
- `RESP`: byte 0 = status, bytes 1-4 = read data LSB first. `tx_valid_o`/`tx_data_o` held stable until `tx_ready_i`; advance only on handshake.
- `rx_valid_i` in `ISSUE`/`WAIT`/`RESP`: byte dropped, `rx_overrun_o` set until reset.
- `dbg_addr_o`/`dbg_data_o` keep their last values between commands.

## Timing
- Reset values: state `CMD`, `tx_valid_o`=0, `tx_data_o`=0, `dbg_cmd_o`=0, `dbg_addr_o`=0, `dbg_data_o`=0, `rx_overrun_o`=0, counters 0.
- All outputs registered. Byte 8 accepted in cycle N → `dbg_cmd_o` valid in N+1 (`ISSUE`), `WAIT` from N+2.
- `dbg_ready_i` is ignored outside `WAIT`, including in `ISSUE`.
- `dbg_ready_i` high in cycle M of `WAIT` → `dbg_cmd_o`=0 and `tx_valid_o`=1 with status byte in M+1.
- With `tx_ready_i` tied high: one response byte per cycle, 5 cycles total; state is `CMD` the cycle after the last handshake. A byte arriving in that cycle is accepted.
- Timeout: `TIMEOUT` cycles of `WAIT` after `ISSUE`, then `RESP` on the next cycle.
- `rst_i` mid-frame or mid-response: everything returns to reset values next cycle; partial frame discarded, no response.

## Structure
- Package `dbg_bridge_pkg`: state enum, `DBG_CMD_NOP`=8'h00, `ST_OK`=8'h00, `ST_TIMEOUT`=8'hEE, frame and response length constants.
- Single module, no sub-modules. Frame capture uses byte-indexed writes into 32-bit registers. Response uses a 40-bit shift register.

## Test plan
- Write frame 0x02, addr 0x00000100, data 0xDEADBEEF; ready 3 cycles after `ISSUE` → `dbg_cmd_o`=0x02 for exactly 4 cycles, addr/data correct; response 00 EF BE AD DE (using `dbg_data_i`=0xDEADBEEF).
- NOP frame → no `dbg_cmd_o` activity; response 00 00 00 00 00.
- `TIMEOUT`=8, ready never asserted → `dbg_cmd_o` nonzero 9 cycles; response EE 00 00 00 00.
- `tx_ready_i` toggled randomly → each byte held stable until handshake; order preserved.
- Extra byte sent during `WAIT` → `rx_overrun_o`=1 stays set; next frame is parsed correctly.
- `rst_i` after byte 4 of a frame, then a full valid frame → only the second frame issued and answered.
